// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of client-side request/response signals and I2C_master control
// signals shared by the transaction arbiter and its environment.
// The "master" modport is the arbiter's view, because the arbiter drives the
// I2C_master datapath. The "slave" modport is the view of the clients plus
// the I2C_master.
interface i2c_txn_arbiter_if #(
  parameter int NREQ = 4
) ();

  // Client side
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rw;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic [1:0]        rsp_err;

  // I2C_master side
  logic              m_start;
  logic              m_rw;
  logic [6:0]        m_addr;
  logic [7:0]        m_wdata;
  logic              m_abort;
  logic              m_busy;
  logic              m_done;
  logic              m_ack;
  logic              m_ack2;
  logic [7:0]        m_rdata;

  modport master (
    input  req, req_rw, req_addr, req_wdata,
    input  m_busy, m_done, m_ack, m_ack2, m_rdata,
    output gnt, rsp_valid, rsp_rdata, rsp_err,
    output m_start, m_rw, m_addr, m_wdata, m_abort
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata,
    output m_busy, m_done, m_ack, m_ack2, m_rdata,
    input  gnt, rsp_valid, rsp_rdata, rsp_err,
    input  m_start, m_rw, m_addr, m_wdata, m_abort
  );

endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C_master between NREQ clients.
// The arbiter grants one client per transaction and launches it on the master.
// It then waits for completion under a watchdog and returns the read data and
// the ACK status to the granted client as a one-cycle response.
module i2c_txn_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  i2c_txn_arbiter_if.master      bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ADDR    = 2'b01,
    ERR_DATA    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  // Registered state and outputs
  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     win_q;
  logic [TW-1:0]     timer_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [7:0]        rsp_rdata_q;
  err_t              rsp_err_q;
  logic              m_start_q;
  logic              m_rw_q;
  logic [6:0]        m_addr_q;
  logic [7:0]        m_wdata_q;
  logic              m_abort_q;

  // Combinational arbitration and completion decode
  logic              found_d;
  logic [IW-1:0]     win_d;
  logic              sel_rw_d;
  logic [6:0]        sel_addr_d;
  logic [7:0]        sel_wdata_d;
  err_t              err_d;
  logic [7:0]        rdata_d;
  logic              timeout_d;

  // Round-robin search: the first pending request starting at ptr, wrapping mod NREQ.
  always_comb begin
    // NOTE: every signal gets a default first so that no latch is inferred.
    found_d = 1'b0;
    win_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int            cand;
      logic [IW-1:0] cand_idx;
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IW'(cand);
      if (!found_d && bus.req[cand_idx]) begin
        found_d = 1'b1;
        win_d   = cand_idx;
      end
    end
  end

  // Pick the winner's direction, address and write byte out of the packed client vectors.
  always_comb begin
    sel_rw_d    = 1'b0;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_d == IW'(i)) begin
        sel_rw_d    = bus.req_rw[i];
        sel_addr_d  = bus.req_addr[7*i +: 7];
        sel_wdata_d = bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Map the master's ACK flags to a response code. An address NACK takes
  // priority, and the data-phase ACK only matters for writes.
  always_comb begin
    err_d   = ERR_OK;
    rdata_d = '0;
    if (!bus.m_ack) begin
      err_d = ERR_ADDR;
    end else if (!m_rw_q && !bus.m_ack2) begin
      err_d = ERR_DATA;
    end else if (m_rw_q) begin
      rdata_d = bus.m_rdata;
    end
  end

  assign timeout_d = (timer_q == TW'(TIMEOUT_CYC - 1));

  // Transaction FSM: grant in IDLE, supervise the master in WAIT, and respond in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      timer_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      m_start_q   <= 1'b0;
      m_rw_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_abort_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      m_start_q <= 1'b0;
      m_abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d && !bus.m_busy) begin
            win_q     <= win_d;
            gnt_q     <= NREQ'(1) << win_d;
            m_rw_q    <= sel_rw_d;
            m_addr_q  <= sel_addr_d;
            m_wdata_q <= sel_wdata_d;
            m_start_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= S_WAIT;
          end
        end

        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (bus.m_done) begin
            // Completion in the final watchdog cycle still counts as a normal finish.
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= err_d;
            rsp_rdata_q <= rdata_d;
            state_q     <= S_RESP;
          end else if (timeout_d) begin
            m_abort_q   <= 1'b1;
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= ERR_TIMEOUT;
            rsp_rdata_q <= '0;
            state_q     <= S_RESP;
          end
        end

        S_RESP: begin
          gnt_q       <= '0;
          rsp_valid_q <= '0;
          ptr_q       <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.m_start   = m_start_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_abort   = m_abort_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed testbench for i2c_txn_arbiter.
// The main instance uses a long watchdog for the functional transactions.
// A second instance uses TIMEOUT_CYC=16 for the watchdog cases.
module tb_i2c_txn_arbiter;

  localparam int NREQ     = 4;
  localparam int TO_MAIN  = 64;
  localparam int TO_SHORT = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(NREQ)) b  ();
  i2c_txn_arbiter_if #(.NREQ(NREQ)) bt ();

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO_MAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO_SHORT)) dut_to (
    .clk   (clk),
    .reset (reset),
    .bus   (bt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge, which is the drive and sample point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic rw, input logic [6:0] a, input logic [7:0] w);
    b.req_rw[i]          = rw;
    b.req_addr[7*i +: 7] = a;
    b.req_wdata[8*i +: 8] = w;
  endtask

  // Master model for the main instance. Called in the m_start cycle, it pulses
  // m_done n cycles later and returns in the RESP cycle.
  task automatic run_master(input int n, input logic ack, input logic ack2, input logic [7:0] rd);
    b.m_busy = 1'b1;
    repeat (n) tick();
    b.m_done  = 1'b1;
    b.m_ack   = ack;
    b.m_ack2  = ack2;
    b.m_rdata = rd;
    b.m_busy  = 1'b0;
    tick();
    b.m_done  = 1'b0;
    b.m_ack   = 1'b0;
    b.m_ack2  = 1'b0;
    b.m_rdata = 8'h00;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    32'(b.gnt),       32'h0);
    check({tag, "_rspv"},   32'(b.rsp_valid), 32'h0);
    check({tag, "_rdata"},  32'(b.rsp_rdata), 32'h0);
    check({tag, "_err"},    32'(b.rsp_err),   32'h0);
    check({tag, "_start"},  32'(b.m_start),   32'h0);
    check({tag, "_rw"},     32'(b.m_rw),      32'h0);
    check({tag, "_addr"},   32'(b.m_addr),    32'h0);
    check({tag, "_wdata"},  32'(b.m_wdata),   32'h0);
    check({tag, "_abort"},  32'(b.m_abort),   32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] exp_g;
    logic [6:0] a7;

    reset = 1'b0;
    b.req = '0;  b.req_rw = '0;  b.req_addr = '0;  b.req_wdata = '0;
    b.m_busy = 1'b0;  b.m_done = 1'b0;  b.m_ack = 1'b0;  b.m_ack2 = 1'b0;  b.m_rdata = '0;
    bt.req = '0; bt.req_rw = '0; bt.req_addr = '0; bt.req_wdata = '0;
    bt.m_busy = 1'b0; bt.m_done = 1'b0; bt.m_ack = 1'b0; bt.m_ack2 = 1'b0; bt.m_rdata = '0;

    // Reset state
    tick();
    tick();
    check_zero("reset");
    check("reset_t_gnt", 32'(bt.gnt), 32'h0);
    reset = 1'b1;
    tick();

    // Write from client 0. The client drops req and changes its inputs during
    // WAIT, and neither change may affect the transaction.
    set_client(0, 1'b0, 7'h66, 8'hE7);
    b.req[0] = 1'b1;
    tick();
    check("wr_gnt",   32'(b.gnt),     32'h1);
    check("wr_start", 32'(b.m_start), 32'h1);
    check("wr_addr",  32'(b.m_addr),  32'h66);
    check("wr_wdata", 32'(b.m_wdata), 32'hE7);
    check("wr_rw",    32'(b.m_rw),    32'h0);
    b.req[0] = 1'b0;
    set_client(0, 1'b1, 7'h01, 8'h00);
    tick();
    check("wr_start_pulse", 32'(b.m_start), 32'h0);
    check("wr_gnt_held",    32'(b.gnt),     32'h1);
    run_master(19, 1'b1, 1'b1, 8'h55);
    check("wr_rspv",       32'(b.rsp_valid), 32'h1);
    check("wr_err",        32'(b.rsp_err),   32'h0);
    check("wr_rdata",      32'(b.rsp_rdata), 32'h0);
    check("wr_addr_held",  32'(b.m_addr),    32'h66);
    check("wr_wdata_held", 32'(b.m_wdata),   32'hE7);
    check("wr_abort",      32'(b.m_abort),   32'h0);
    tick();
    check("wr_idle_gnt",  32'(b.gnt),       32'h0);
    check("wr_idle_rspv", 32'(b.rsp_valid), 32'h0);
    check("wr_idle_addr", 32'(b.m_addr),    32'h66);

    // Address NACK on a read from client 1: the code is 01 and rdata is forced to 0.
    set_client(1, 1'b1, 7'h66, 8'h00);
    b.req[1] = 1'b1;
    tick();
    check("an_gnt", 32'(b.gnt),  32'h2);
    check("an_rw",  32'(b.m_rw), 32'h1);
    run_master(4, 1'b0, 1'b1, 8'h5A);
    check("an_rspv",  32'(b.rsp_valid), 32'h2);
    check("an_err",   32'(b.rsp_err),   32'h1);
    check("an_rdata", 32'(b.rsp_rdata), 32'h0);
    b.req[1] = 1'b0;
    tick();

    // Read from client 2: m_ack2=0 must not matter for a read.
    set_client(2, 1'b1, 7'h66, 8'h00);
    b.req[2] = 1'b1;
    tick();
    check("rd_gnt",  32'(b.gnt),    32'h4);
    check("rd_addr", 32'(b.m_addr), 32'h66);
    run_master(6, 1'b1, 1'b0, 8'hAA);
    check("rd_rspv",  32'(b.rsp_valid), 32'h4);
    check("rd_err",   32'(b.rsp_err),   32'h0);
    check("rd_rdata", 32'(b.rsp_rdata), 32'hAA);
    b.req[2] = 1'b0;
    tick();

    // Data NACK on a write from client 3.
    set_client(3, 1'b0, 7'h50, 8'h99);
    b.req[3] = 1'b1;
    tick();
    check("dn_gnt",   32'(b.gnt),     32'h8);
    check("dn_wdata", 32'(b.m_wdata), 32'h99);
    run_master(2, 1'b1, 1'b0, 8'h77);
    check("dn_rspv",  32'(b.rsp_valid), 32'h8);
    check("dn_err",   32'(b.rsp_err),   32'h2);
    check("dn_rdata", 32'(b.rsp_rdata), 32'h0);
    b.req[3] = 1'b0;
    tick();

    // Fairness: all four requests held, ptr is back at 0, so the order is 0,1,2,3,0,1.
    for (int i = 0; i < NREQ; i++) begin
      a7 = 7'h10 + 7'(i);
      set_client(i, 1'b0, a7, 8'hA0);
    end
    b.req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_g = 4'b0001 << (k % 4);
      a7    = 7'h10 + 7'(k % 4);
      tick();
      check($sformatf("rr%0d_gnt", k),   32'(b.gnt),     32'(exp_g));
      check($sformatf("rr%0d_start", k), 32'(b.m_start), 32'h1);
      check($sformatf("rr%0d_addr", k),  32'(b.m_addr),  32'(a7));
      run_master(10, 1'b1, 1'b1, 8'h00);
      check($sformatf("rr%0d_rspv", k),  32'(b.rsp_valid), 32'(exp_g));
      check($sformatf("rr%0d_gnt_r", k), 32'(b.gnt),       32'(exp_g));
      if (k == 5) b.req = '0;
      tick();
      check($sformatf("rr%0d_idle", k), 32'(b.gnt), 32'h0);
    end

    // Reset in the middle of WAIT. Before the reset, ptr is 2.
    set_client(2, 1'b0, 7'h2A, 8'h3C);
    b.req[2] = 1'b1;
    tick();
    check("rst_pre_gnt", 32'(b.gnt), 32'h4);
    b.m_busy = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1 check_zero("rst_async");
    b.req = '0;
    set_client(1, 1'b0, 7'h11, 8'h01);
    set_client(3, 1'b0, 7'h33, 8'h03);
    b.req[1] = 1'b1;
    b.req[3] = 1'b1;
    tick();
    check("rst_held_gnt", 32'(b.gnt), 32'h0);
    reset = 1'b1;
    tick();
    check("busy_blk_gnt", 32'(b.gnt), 32'h0);
    // m_done received in IDLE must be ignored.
    b.m_done = 1'b1;
    b.m_ack  = 1'b1;
    tick();
    check("busy_blk_gnt2", 32'(b.gnt),       32'h0);
    check("idle_done_rsp", 32'(b.rsp_valid), 32'h0);
    b.m_done = 1'b0;
    b.m_ack  = 1'b0;
    b.m_busy = 1'b0;
    tick();
    check("post_rst_gnt",   32'(b.gnt),     32'h2);
    check("post_rst_addr",  32'(b.m_addr),  32'h11);
    check("post_rst_start", 32'(b.m_start), 32'h1);
    run_master(3, 1'b1, 1'b1, 8'h00);
    check("post_rst_rspv", 32'(b.rsp_valid), 32'h2);
    b.req = '0;
    tick();

    // Watchdog instance: m_done arrives in the last allowed cycle (timer=15), so the transaction finishes normally.
    bt.req_rw[0]        = 1'b1;
    bt.req_addr[6:0]    = 7'h48;
    bt.req[0]           = 1'b1;
    tick();
    check("tc_gnt",   32'(bt.gnt),     32'h1);
    check("tc_start", 32'(bt.m_start), 32'h1);
    bt.m_busy = 1'b1;
    repeat (15) tick();
    bt.m_done  = 1'b1;
    bt.m_ack   = 1'b1;
    bt.m_ack2  = 1'b0;
    bt.m_rdata = 8'hC3;
    check("tc_c15_abort", 32'(bt.m_abort), 32'h0);
    tick();
    check("tc_abort", 32'(bt.m_abort),   32'h0);
    check("tc_rspv",  32'(bt.rsp_valid), 32'h1);
    check("tc_err",   32'(bt.rsp_err),   32'h0);
    check("tc_rdata", 32'(bt.rsp_rdata), 32'hC3);
    bt.m_done  = 1'b0;
    bt.m_ack   = 1'b0;
    bt.m_rdata = 8'h00;
    bt.m_busy  = 1'b0;
    bt.req[0]  = 1'b0;
    tick();

    // Watchdog instance: the master never finishes, so there is an abort and err=11 sixteen cycles after m_start.
    bt.req_rw[1]        = 1'b0;
    bt.req_addr[13:7]   = 7'h21;
    bt.req[1]           = 1'b1;
    tick();
    check("to_gnt", 32'(bt.gnt), 32'h2);
    bt.m_busy = 1'b1;
    repeat (15) tick();
    check("to_c15_abort", 32'(bt.m_abort),   32'h0);
    check("to_c15_rspv",  32'(bt.rsp_valid), 32'h0);
    tick();
    check("to_abort", 32'(bt.m_abort),   32'h1);
    check("to_err",   32'(bt.rsp_err),   32'h3);
    check("to_rdata", 32'(bt.rsp_rdata), 32'h0);
    check("to_rspv",  32'(bt.rsp_valid), 32'h2);
    check("to_gnt_r", 32'(bt.gnt),       32'h2);
    bt.req[1]  = 1'b0;
    bt.m_busy  = 1'b0;
    tick();
    check("to_abort_pulse", 32'(bt.m_abort), 32'h0);
    check("to_idle_gnt",    32'(bt.gnt),     32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Round-robin scheduler that shares the single I2C_master datapath between NREQ client requesters.
- Samples pending requests and grants one client per transaction.
- Launches the transaction on the master, waits for its completion with a watchdog, then returns read data and ACK status to the granted client.
- Sits between system-side clients (config engines, sensor pollers) and I2C_master.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 4096, clk cycles allowed from m_start to m_done before abort (>=4)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-client request, level; hold until own rsp_valid
- req_rw  in  NREQ  per-client direction, 1=read, 0=write
- req_addr  in  7*NREQ  per-client 7-bit slave address, client i at [7i+6:7i]
- req_wdata  in  8*NREQ  per-client write byte, client i at [8i+7:8i]
- gnt  out  NREQ  one-hot grant, held for whole transaction
- rsp_valid  out  NREQ  one-cycle completion pulse to granted client
- rsp_rdata  out  8  read byte, valid with rsp_valid
- rsp_err  out  2  00 ok, 01 address NACK, 10 data NACK, 11 timeout
- m_start  out  1  one-cycle launch pulse to I2C_master
- m_rw  out  1  latched direction to master
- m_addr  out  7  latched address to master
- m_wdata  out  8  latched write byte to master
- m_abort  out  1  one-cycle pulse forcing master to STOP/idle
- m_busy  in  1  master transaction in progress
- m_done  in  1  one-cycle completion pulse from master
- m_ack  in  1  address-phase ACK (1=acked), valid with m_done
- m_ack2  in  1  data-phase ACK (1=acked), valid with m_done
- m_rdata  in  8  byte read by master, valid with m_done

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr pointer ptr=0, timer=0. All outputs 0: gnt, rsp_valid, rsp_rdata, rsp_err, m_start, m_rw, m_addr, m_wdata, m_abort. Reset mid-transaction drops everything with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req bit is set and m_busy=0: pick the first set bit searching ptr, ptr+1, … mod NREQ.
  - At that edge: gnt=onehot(winner); latch m_rw/m_addr/m_wdata from the winner's slice; m_start=1 for exactly one cycle; timer=0; go to WAIT.
  - Grant/start latency is 1 cycle from the first clock edge seeing req.
  - m_busy=1 blocks granting. m_done/m_ack/m_ack2 in IDLE are ignored.
- WAIT:
  - timer increments each cycle.
  - On m_done: go to RESP with:
    - rsp_err=01 if m_ack=0 (rsp_rdata=0)
    - else rsp_err=10 if write and m_ack2=0
    - else rsp_err=00 with rsp_rdata=m_rdata for a read, 0 for a write.
    - m_ack2 is ignored on reads.
  - If timer reaches TIMEOUT_CYC-1 with no m_done: m_abort=1 for one cycle, rsp_err=11, rsp_rdata=0, go to RESP.
  - m_done in the same cycle as timeout: m_done wins, no abort.
  - Changes on req and other clients' inputs during WAIT are ignored. Latched m_* values stay stable.
- RESP (one cycle):
  - rsp_valid[winner]=1, gnt still asserted.
  - Next edge: gnt=0, rsp_valid=0, ptr=(winner+1) mod NREQ, go to IDLE.
- A client deasserting req while granted does not cancel; the response is still issued.
- Minimum spacing between successive m_start pulses is 3 cycles: a new grant is possible the cycle after RESP.
- m_rw/m_addr/m_wdata hold their last values between transactions.

Test Plan:
- Write, client 0: req[0]=1, addr 7'h66, wdata 8'hE7; master m_done after 20 cycles with ack=1, ack2=1 -> gnt=0001 and m_start one cycle after req; m_addr=66, m_wdata=E7, m_rw=0; rsp_valid[0] pulse, rsp_err=00.
- Read, client 2: req[2]=1, rw=1, addr 7'h66, m_rdata=8'hAA, ack=1, ack2=0 -> gnt=0100, rsp_rdata=AA, rsp_err=00.
- Fairness: all four reqs held high continuously, each master transaction 10 cycles -> grant order 0,1,2,3,0,1. Exactly one gnt bit high at any time.
- NACKs: address NACK (m_ack=0) -> rsp_err=01, rdata=00. Write with m_ack=1, m_ack2=0 -> rsp_err=10.
- Timeout, TIMEOUT_CYC=16, master never asserts m_done -> m_abort pulse and rsp_err=11 in the cycle 16 cycles after m_start. Repeat with m_done arriving on the timeout cycle -> no abort, err taken from acks.
- Reset mid-WAIT: reset low -> all outputs 0 asynchronously, no rsp_valid. After release with m_busy=1 and req[1]=1 -> no grant until m_busy=0, then gnt=0010 (ptr restarted at 0).
